// File: rtl/uart_cmd_if.sv
// Bus between the UART receiver side and the command parser.
// Handshake: rx_vld is a one-cycle strobe with no back-pressure. rx_data is
// meaningful only while rx_vld=1, and each high cycle delivers exactly one byte.
// wr_en, sum_err and tmo_err are single-cycle strobes. wr_addr and wr_data
// hold their value between accepted frames.
interface uart_cmd_if;
  logic       rx_vld;
  logic [7:0] rx_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       sum_err;
  logic       tmo_err;
  logic [7:0] err_cnt;
  logic       busy;

  // Byte source side (receiver or testbench).
  modport master (
    output rx_vld, rx_data,
    input  wr_en, wr_addr, wr_data, sum_err, tmo_err, err_cnt, busy
  );

  // Parser side.
  modport slave (
    input  rx_vld, rx_data,
    output wr_en, wr_addr, wr_data, sum_err, tmo_err, err_cnt, busy
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Frames a UART byte stream into HEAD/ADDR/DATA/SUM register-write commands.
// Bad checksums and inter-byte stalls drop the frame and bump a saturating
// error counter. All outputs are registered.
module uart_cmd_parser #(
  parameter logic [7:0] HEAD    = 8'h55,
  parameter int         TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_cmd_if.slave  bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_SUM  = 2'd3
  } state_t;

  localparam int            CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en_q, wr_en_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          sum_err_q, sum_err_d;
  logic          tmo_err_q, tmo_err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          busy_q, busy_d;
  logic [7:0]    exp_sum;

  // Expected checksum: 8-bit sum, carry discarded.
  assign exp_sum = addr_q + data_q;

  // Next state, timeout counter and registered-output inputs.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    sum_err_d = 1'b0;
    tmo_err_d = 1'b0;
    err_cnt_d = err_cnt_q;

    if (bus.rx_vld) begin
      // A byte always wins over a simultaneous timeout expiry.
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (bus.rx_data == HEAD) state_d = S_ADDR;
        end
        S_ADDR: begin
          // No resync: a HEAD value here is just an address.
          addr_d  = bus.rx_data;
          state_d = S_DATA;
        end
        S_DATA: begin
          data_d  = bus.rx_data;
          state_d = S_SUM;
        end
        S_SUM: begin
          if (bus.rx_data == exp_sum) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = data_q;
          end else begin
            sum_err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      state_d   = IDLE;
      tmo_err_d = 1'b1;
      cnt_d     = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // The two error sources are mutually exclusive, so at most +1 per cycle.
    if ((sum_err_d || tmo_err_d) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      sum_err_q <= 1'b0;
      tmo_err_q <= 1'b0;
      err_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      sum_err_q <= sum_err_d;
      tmo_err_q <= tmo_err_d;
      err_cnt_q <= err_cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.sum_err = sum_err_q;
  assign bus.tmo_err = tmo_err_q;
  assign bus.err_cnt = err_cnt_q;
  assign bus.busy    = busy_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a short TIMEOUT.
module tb_uart_cmd_parser;

  localparam int TMO = 20;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         tests;
  int         fails;
  int         wr_seen;
  int         sum_seen;
  int         tmo_seen;

  uart_cmd_if bus ();

  uart_cmd_parser #(.HEAD(8'h55), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (bus.wr_en)   wr_seen++;
    if (bus.sum_err) sum_seen++;
    if (bus.tmo_err) tmo_seen++;
  end

  task automatic clear_seen();
    wr_seen = 0;
    sum_seen = 0;
    tmo_seen = 0;
  endtask

  // Driver: called at a negedge; presents one byte for one cycle and
  // returns at the following negedge, where the registered result is visible.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_vld  = 1'b1;
    bus.rx_data = b;
    @(negedge clk);
    bus.rx_vld  = 1'b0;
    bus.rx_data = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rx_vld = 1'b0;
    bus.rx_data = 8'h00;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    tests++; if (bus.wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got %b exp 0", bus.wr_en); end
    tests++; if (bus.wr_addr !== 8'h00) begin fails++; $display("FAIL reset_wr_addr got %h exp 00", bus.wr_addr); end
    tests++; if (bus.wr_data !== 8'h00) begin fails++; $display("FAIL reset_wr_data got %h exp 00", bus.wr_data); end
    tests++; if (bus.sum_err !== 1'b0 || bus.tmo_err !== 1'b0) begin fails++; $display("FAIL reset_err_pulses got %b%b exp 00", bus.sum_err, bus.tmo_err); end
    tests++; if (bus.err_cnt !== 8'h00) begin fails++; $display("FAIL reset_err_cnt got %h exp 00", bus.err_cnt); end
    tests++; if (bus.busy !== 1'b0 || dbg_state !== 2'd0) begin fails++; $display("FAIL reset_busy_state got %b/%0d exp 0/0", bus.busy, dbg_state); end
  endtask

  task automatic test_gapped_frame();
    clear_seen();
    send_byte(8'h55);
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL gap_busy_rise got %b exp 1", bus.busy); end
    idle(10); send_byte(8'h12);
    idle(10); send_byte(8'h34);
    idle(10); send_byte(8'h46);
    tests++; if (bus.wr_en !== 1'b1) begin fails++; $display("FAIL gap_wr_en got %b exp 1", bus.wr_en); end
    tests++; if (bus.wr_addr !== 8'h12 || bus.wr_data !== 8'h34) begin fails++; $display("FAIL gap_addr_data got %h/%h exp 12/34", bus.wr_addr, bus.wr_data); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL gap_busy_fall got %b exp 0", bus.busy); end
    idle(1);
    tests++; if (bus.wr_en !== 1'b0) begin fails++; $display("FAIL gap_wr_en_width got %b exp 0", bus.wr_en); end
    tests++; if (wr_seen != 1 || bus.err_cnt !== 8'h00) begin fails++; $display("FAIL gap_counts got wr=%0d err=%h exp 1/00", wr_seen, bus.err_cnt); end
  endtask

  task automatic test_leading_garbage();
    clear_seen();
    send_byte(8'h00);
    send_byte(8'hAA);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL garbage_ignored busy got %b exp 0", bus.busy); end
    send_byte(8'h55);
    send_byte(8'hFF);
    send_byte(8'h02);
    send_byte(8'h01);
    tests++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'hFF || bus.wr_data !== 8'h02) begin fails++; $display("FAIL garbage_frame got %b %h/%h exp 1 FF/02", bus.wr_en, bus.wr_addr, bus.wr_data); end
  endtask

  task automatic test_sum_err();
    clear_seen();
    send_byte(8'h55);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h47);
    tests++; if (bus.sum_err !== 1'b1 || bus.wr_en !== 1'b0) begin fails++; $display("FAIL sum_err_pulse got sum=%b wr=%b exp 1/0", bus.sum_err, bus.wr_en); end
    tests++; if (bus.err_cnt !== 8'h01) begin fails++; $display("FAIL sum_err_cnt got %h exp 01", bus.err_cnt); end
    tests++; if (bus.wr_addr !== 8'hFF || bus.wr_data !== 8'h02) begin fails++; $display("FAIL sum_err_hold got %h/%h exp FF/02", bus.wr_addr, bus.wr_data); end
    idle(1);
    tests++; if (bus.sum_err !== 1'b0 || sum_seen != 1 || wr_seen != 0) begin fails++; $display("FAIL sum_err_width got %b seen=%0d wr=%0d exp 0/1/0", bus.sum_err, sum_seen, wr_seen); end
  endtask

  task automatic test_timeout();
    clear_seen();
    send_byte(8'h55);
    send_byte(8'h12);
    idle(TMO - 1);
    tests++; if (bus.tmo_err !== 1'b0 || bus.busy !== 1'b1) begin fails++; $display("FAIL tmo_early got tmo=%b busy=%b exp 0/1", bus.tmo_err, bus.busy); end
    idle(1);
    tests++; if (bus.tmo_err !== 1'b1 || bus.busy !== 1'b0) begin fails++; $display("FAIL tmo_fire got tmo=%b busy=%b exp 1/0", bus.tmo_err, bus.busy); end
    tests++; if (bus.err_cnt !== 8'h02) begin fails++; $display("FAIL tmo_err_cnt got %h exp 02", bus.err_cnt); end
    idle(5);
    tests++; if (tmo_seen != 1) begin fails++; $display("FAIL tmo_single got %0d exp 1", tmo_seen); end
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    tests++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'h01 || bus.wr_data !== 8'h02) begin fails++; $display("FAIL tmo_recover got %b %h/%h exp 1 01/02", bus.wr_en, bus.wr_addr, bus.wr_data); end
  endtask

  task automatic test_expiry_race();
    clear_seen();
    send_byte(8'h55);
    send_byte(8'h12);
    idle(TMO - 1);
    send_byte(8'h34);
    tests++; if (bus.tmo_err !== 1'b0 || bus.busy !== 1'b1) begin fails++; $display("FAIL race_byte_wins got tmo=%b busy=%b exp 0/1", bus.tmo_err, bus.busy); end
    send_byte(8'h46);
    tests++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'h12 || bus.wr_data !== 8'h34) begin fails++; $display("FAIL race_frame got %b %h/%h exp 1 12/34", bus.wr_en, bus.wr_addr, bus.wr_data); end
    tests++; if (tmo_seen != 0 || bus.err_cnt !== 8'h02) begin fails++; $display("FAIL race_no_err got tmo=%0d err=%h exp 0/02", tmo_seen, bus.err_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    clear_seen();
    send_byte(8'h55);
    send_byte(8'h12);
    rst_n = 1'b0;
    #1;
    tests++; if (bus.busy !== 1'b0 || dbg_state !== 2'd0) begin fails++; $display("FAIL rst_mid_state got %b/%0d exp 0/0", bus.busy, dbg_state); end
    tests++; if (bus.wr_addr !== 8'h00 || bus.wr_data !== 8'h00 || bus.err_cnt !== 8'h00) begin fails++; $display("FAIL rst_mid_regs got %h/%h/%h exp 00/00/00", bus.wr_addr, bus.wr_data, bus.err_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send_byte(8'h55);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'h78);
    tests++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'hAB || bus.wr_data !== 8'hCD) begin fails++; $display("FAIL rst_mid_next got %b %h/%h exp 1 AB/CD", bus.wr_en, bus.wr_addr, bus.wr_data); end
    tests++; if (bus.err_cnt !== 8'h00 || tmo_seen != 0) begin fails++; $display("FAIL rst_mid_no_err got %h/%0d exp 00/0", bus.err_cnt, tmo_seen); end
  endtask

  task automatic test_back_to_back();
    clear_seen();
    send_byte(8'h55); send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    tests++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'h10 || bus.wr_data !== 8'h20) begin fails++; $display("FAIL b2b_first got %b %h/%h exp 1 10/20", bus.wr_en, bus.wr_addr, bus.wr_data); end
    send_byte(8'h55); send_byte(8'hF0); send_byte(8'h20); send_byte(8'h10);
    tests++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'hF0 || bus.wr_data !== 8'h20) begin fails++; $display("FAIL b2b_second got %b %h/%h exp 1 F0/20", bus.wr_en, bus.wr_addr, bus.wr_data); end
    idle(1);
    tests++; if (wr_seen != 2 || bus.err_cnt !== 8'h00) begin fails++; $display("FAIL b2b_counts got wr=%0d err=%h exp 2/00", wr_seen, bus.err_cnt); end
  endtask

  task automatic test_saturation();
    clear_seen();
    for (int i = 0; i < 260; i++) begin
      send_byte(8'h55); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
      if (i == 253) begin
        tests++; if (bus.err_cnt !== 8'hFE) begin fails++; $display("FAIL sat_254 got %h exp FE", bus.err_cnt); end
      end
      if (i == 254) begin
        tests++; if (bus.err_cnt !== 8'hFF) begin fails++; $display("FAIL sat_255 got %h exp FF", bus.err_cnt); end
      end
    end
    idle(1);
    tests++; if (bus.err_cnt !== 8'hFF) begin fails++; $display("FAIL sat_hold got %h exp FF", bus.err_cnt); end
    tests++; if (sum_seen != 260 || wr_seen != 0) begin fails++; $display("FAIL sat_pulses got sum=%0d wr=%0d exp 260/0", sum_seen, wr_seen); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clear_seen();
    test_reset();
    test_gapped_frame();
    test_leading_garbage();
    test_sum_err();
    test_timeout();
    test_expiry_race();
    test_reset_mid_frame();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-level command controller placed directly downstream of the UART receiver. It consumes the receiver's `rx_vld`/`rx_data` byte stream and frames it into 4-byte register-write commands: header, address, data, checksum. Valid frames produce a single-cycle register write strobe. Malformed or stalled frames are discarded and counted.

## Interface

Parameters
- `HEAD`, default 8'h55: frame header byte.
- `TIMEOUT`, default 1000: maximum idle clocks allowed between consecutive bytes of one frame before the frame is dropped. Legal range is 2 or more.

Ports
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_vld`  in  1  one-cycle strobe: `rx_data` holds a received byte.
- `rx_data`  in  8  received byte; sampled only when `rx_vld`=1.
- `wr_en`  out  1  one-cycle register-write strobe.
- `wr_addr`  out  8  write address; held until the next accepted frame.
- `wr_data`  out  8  write data; held until the next accepted frame.
- `sum_err`  out  1  one-cycle pulse: checksum mismatch.
- `tmo_err`  out  1  one-cycle pulse: inter-byte timeout.
- `err_cnt`  out  8  count of `sum_err` plus `tmo_err` events; saturates at 255.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation

- Frame format: `HEAD`, ADDR, DATA, SUM, where SUM = (ADDR + DATA) mod 256, computed as an 8-bit sum with the carry discarded.
- States and transitions. All transitions occur only on cycles with `rx_vld`=1, except the timeout.
  - IDLE: byte == `HEAD` → S_ADDR. Any other byte is ignored and IDLE is kept.
  - S_ADDR: latch the byte into the internal addr register → S_DATA. A byte equal to `HEAD` is treated as an ordinary address; there is no resync.
  - S_DATA: latch the byte into the internal data register → S_SUM.
  - S_SUM, byte == (addr + data) mod 256: load `wr_addr`/`wr_data`, pulse `wr_en` → IDLE.
  - S_SUM, mismatch: pulse `sum_err`, increment `err_cnt`; `wr_addr`/`wr_data` are unchanged → IDLE.
- Timeout counter:
  - Clears on every `rx_vld`.
  - Clears while in IDLE.
  - Otherwise increments by 1 per clock.
  - On reaching `TIMEOUT`-1 with no `rx_vld` in that cycle: go to IDLE, pulse `tmo_err`, increment `err_cnt`, clear the counter.
- Simultaneous byte and timeout expiry in the same cycle: the byte wins. It is processed normally, the counter clears, and there is no `tmo_err`.
- `sum_err` and `tmo_err` are never asserted in the same cycle, so `err_cnt` increments by at most 1 per cycle.
- `err_cnt` saturates: it holds at 255 with no wrap.
- Internal addr/data registers are overwritten by each new frame. They are not cleared on error.

## Timing

- Reset values: state IDLE, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `sum_err`=0, `tmo_err`=0, `err_cnt`=0, `busy`=0, timeout counter 0.
- All outputs are registered.
- `wr_en` and `sum_err` rise on the clock edge after the cycle in which the SUM byte's `rx_vld` is high. Latency is 1 clock.
- `wr_addr` and `wr_data` become valid in the same cycle as `wr_en`.
- `tmo_err` rises 1 clock after the expiry cycle.
- All pulses are exactly 1 cycle wide.
- `busy` rises 1 clock after the `HEAD` byte is accepted. It falls 1 clock after the SUM byte or the timeout expiry.
- Back-to-back frames are supported. A `HEAD` byte arriving in the cycle immediately after a SUM byte is accepted.
- Reset asserted mid-frame: all state returns to reset values immediately. Any partial frame is lost and no error is counted.
- `rx_vld` may be asserted on consecutive cycles. Each such cycle consumes one byte.

## Test plan

- Send 55,12,34,46 with 10-clock gaps → exactly one `wr_en` pulse, 1 clock after the last byte. `wr_addr`=12, `wr_data`=34. `err_cnt`=0.
- Send 00,AA,55,FF,02,01 → leading 00 and AA are ignored. Frame is accepted: `wr_addr`=FF, `wr_data`=02, since FF+02 = 01 mod 256.
- Send 55,12,34,47 → one `sum_err` pulse, no `wr_en`, `err_cnt`=1. `wr_addr`/`wr_data` keep their previous values.
- Send 55,12 then wait `TIMEOUT`+5 clocks → one `tmo_err` pulse at the `TIMEOUT`-1 boundary and `busy` falls. A following clean frame 55,01,02,03 gives `wr_en`.
- Deliver the DATA byte exactly on the expiry cycle (`TIMEOUT`-1 idle clocks after the address byte) → no `tmo_err`, and the frame completes normally. Assert `rst_n`=0 after 55,12 → outputs return to reset values and the next full frame is accepted.
- Send 260 bad-checksum frames → `err_cnt` saturates at 255 and holds.
